// File: rtl/port_allocator_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// port_allocator_rr : wormhole output-port allocator, per-output RR arbitration
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module port_allocator_rr #(
   parameter int PORTS     = 5,
   parameter int LOG_PORTS = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PORTS-1:0]             req_valid_i,
   input  logic [PORTS*LOG_PORTS-1:0]   req_outport_i,
   input  logic [PORTS-1:0]             req_tail_i,
   input  logic [PORTS-1:0]             out_ready_i,
   output logic [PORTS-1:0]             in_grant_o,
   output logic [PORTS-1:0]             out_occupied_o,
   output logic [PORTS*LOG_PORTS-1:0]   out_owner_o,
   output logic                         bad_req_o
);

   typedef logic [LOG_PORTS-1:0] port_id_t;

   typedef enum logic [0:0] {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e   state_q [PORTS];
   state_e   state_d [PORTS];
   port_id_t owner_q [PORTS];
   port_id_t owner_d [PORTS];
   port_id_t ptr_q   [PORTS];
   port_id_t ptr_d   [PORTS];
   logic     bad_q;
   logic     bad_d;

   port_id_t         w_req_port [PORTS];
   logic [PORTS-1:0] w_owns_any;
   logic [PORTS-1:0] w_grant;

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         w_req_port[i] = req_outport_i[i*LOG_PORTS +: LOG_PORTS];
      end
   end

   // An input already holding an output is kept out of every other candidate set.
   always_comb begin
      w_owns_any = '0;
      for (int o = 0; o < PORTS; o++) begin
         for (int i = 0; i < PORTS; i++) begin
            if (state_q[o] == ST_LOCKED && owner_q[o] == port_id_t'(i)) begin
               w_owns_any[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bad_d = bad_q;
      for (int i = 0; i < PORTS; i++) begin
         if (req_valid_i[i] && (int'(w_req_port[i]) >= PORTS)) begin
            bad_d = 1'b1;
         end
      end
   end

   always_comb begin
      int   idx;
      int   win;
      int   nxt;
      int   own;
      logic found;
      logic xfer;
      w_grant = '0;
      idx     = 0;
      win     = 0;
      nxt     = 0;
      own     = 0;
      found   = 1'b0;
      xfer    = 1'b0;
      for (int o = 0; o < PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (state_q[o] == ST_FREE) begin
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < PORTS; k++) begin
               idx = int'(ptr_q[o]) + k;
               if (idx >= PORTS) begin
                  idx = idx - PORTS;
               end
               if (!found && req_valid_i[idx] && !w_owns_any[idx] &&
                   w_req_port[idx] == port_id_t'(o)) begin
                  found = 1'b1;
                  win   = idx;
               end
            end
            if (found) begin
               nxt = win + 1;
               if (nxt >= PORTS) begin
                  nxt = 0;
               end
               state_d[o] = ST_LOCKED;
               owner_d[o] = port_id_t'(win);
               ptr_d[o]   = port_id_t'(nxt);
            end
         end else begin
            own  = int'(owner_q[o]);
            xfer = req_valid_i[own] && out_ready_i[o] && (w_req_port[own] == port_id_t'(o));
            if (xfer) begin
               w_grant[own] = 1'b1;
               if (req_tail_i[own]) begin
                  state_d[o] = ST_FREE;
                  owner_d[o] = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int o = 0; o < PORTS; o++) begin
            state_q[o] <= ST_FREE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
         bad_q <= 1'b0;
      end else begin
         for (int o = 0; o < PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
         bad_q <= bad_d;
      end
   end

   // Grants are suppressed for as long as reset is held, not just until the next edge.
   always_comb begin
      in_grant_o = rst ? '0 : w_grant;
      for (int o = 0; o < PORTS; o++) begin
         out_occupied_o[o]                         = (state_q[o] == ST_LOCKED);
         out_owner_o[o*LOG_PORTS +: LOG_PORTS]     = owner_q[o];
      end
   end

   assign bad_req_o = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_port_allocator_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_port_allocator_rr : directed self-checking bench for port_allocator_rr
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_port_allocator_rr;

   localparam int PORTS     = 5;
   localparam int LOG_PORTS = 3;

   logic                       clk;
   logic                       rst;
   logic [PORTS-1:0]           req_valid;
   logic [PORTS*LOG_PORTS-1:0] req_outport;
   logic [PORTS-1:0]           req_tail;
   logic [PORTS-1:0]           out_ready;
   logic [PORTS-1:0]           in_grant;
   logic [PORTS-1:0]           out_occupied;
   logic [PORTS*LOG_PORTS-1:0] out_owner;
   logic                       bad_req;

   int total;
   int passed;

   port_allocator_rr #(
      .PORTS     (PORTS),
      .LOG_PORTS (LOG_PORTS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_outport_i  (req_outport),
      .req_tail_i     (req_tail),
      .out_ready_i    (out_ready),
      .in_grant_o     (in_grant),
      .out_occupied_o (out_occupied),
      .out_owner_o    (out_owner),
      .bad_req_o      (bad_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input int o, input logic tail);
      req_valid[i]                         = 1'b1;
      req_outport[i*LOG_PORTS +: LOG_PORTS] = LOG_PORTS'(o);
      req_tail[i]                          = tail;
   endtask

   task automatic clear_reqs();
      req_valid   = '0;
      req_outport = '0;
      req_tail    = '0;
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      rst       = 1'b1;
      out_ready = '1;
      clear_reqs();
      #1;
      chk("reset_occ",   32'(out_occupied), 32'h0);
      chk("reset_owner", 32'(out_owner),    32'h0);
      chk("reset_grant", 32'(in_grant),     32'h0);
      chk("reset_bad",   32'(bad_req),      32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Reset mid-packet: input 1 holds output 2
      set_req(1, 2, 1'b0);
      #1;
      chk("alloc_no_grant", 32'(in_grant), 32'h0);
      tick();
      chk("lock_occ",   32'(out_occupied), 32'b00100);
      chk("lock_owner", 32'(out_owner),    32'd64);
      chk("lock_grant", 32'(in_grant),     32'b00010);
      rst = 1'b1;
      #1;
      chk("rst_mid_occ",   32'(out_occupied), 32'h0);
      chk("rst_mid_owner", 32'(out_owner),    32'h0);
      chk("rst_mid_grant", 32'(in_grant),     32'h0);
      tick();
      chk("rst_hold_grant", 32'(in_grant), 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_free", 32'(out_occupied), 32'h0);
      tick();
      chk("relock_occ",   32'(out_occupied), 32'b00100);
      chk("relock_grant", 32'(in_grant),     32'b00010);
      req_tail[1] = 1'b1;
      tick();
      chk("relock_release", 32'(out_occupied), 32'h0);
      clear_reqs();

      // Single-flit packet: input 3 -> output 0
      set_req(3, 0, 1'b1);
      #1;
      chk("sf_cycle0_grant", 32'(in_grant), 32'h0);
      tick();
      chk("sf_occ",   32'(out_occupied), 32'b00001);
      chk("sf_owner", 32'(out_owner),    32'd3);
      chk("sf_grant", 32'(in_grant),     32'b01000);
      tick();
      clear_reqs();
      chk("sf_release", 32'(out_occupied), 32'h0);

      // Round robin on output 1 among inputs 0, 2, 4
      set_req(0, 1, 1'b1);
      set_req(2, 1, 1'b1);
      set_req(4, 1, 1'b1);
      tick();
      chk("rr0_owner", 32'(out_owner),    32'd0);
      chk("rr0_occ",   32'(out_occupied), 32'b00010);
      chk("rr0_grant", 32'(in_grant),     32'b00001);
      tick();
      chk("rr_bubble1_occ",   32'(out_occupied), 32'h0);
      chk("rr_bubble1_grant", 32'(in_grant),     32'h0);
      tick();
      chk("rr1_owner", 32'(out_owner), 32'd16);
      chk("rr1_grant", 32'(in_grant),  32'b00100);
      tick();
      chk("rr_bubble2_occ", 32'(out_occupied), 32'h0);
      tick();
      chk("rr2_owner", 32'(out_owner), 32'd32);
      chk("rr2_grant", 32'(in_grant),  32'b10000);
      tick();
      chk("rr_bubble3_occ", 32'(out_occupied), 32'h0);
      tick();
      chk("rr3_owner", 32'(out_owner),    32'd0);
      chk("rr3_occ",   32'(out_occupied), 32'b00010);
      chk("rr3_grant", 32'(in_grant),     32'b00001);
      tick();
      clear_reqs();
      chk("rr_done_occ", 32'(out_occupied), 32'h0);

      // Wormhole hold on output 3: input 1 sends 4 flits, input 2 waits
      set_req(1, 3, 1'b0);
      set_req(2, 3, 1'b1);
      tick();
      chk("wh_owner", 32'(out_owner), 32'd512);
      for (int f = 0; f < 4; f++) begin
         if (f == 3) req_tail[1] = 1'b1;
         #1;
         chk($sformatf("wh_flit%0d_grant", f), 32'(in_grant), 32'b00010);
         tick();
      end
      req_valid[1] = 1'b0;
      req_tail[1]  = 1'b0;
      #1;
      chk("wh_bubble_grant", 32'(in_grant),     32'h0);
      chk("wh_bubble_occ",   32'(out_occupied), 32'h0);
      tick();
      chk("wh_next_owner", 32'(out_owner), 32'd1024);
      chk("wh_next_grant", 32'(in_grant),  32'b00100);
      tick();
      clear_reqs();
      chk("wh_done_occ", 32'(out_occupied), 32'h0);

      // Back-pressure on output 4, input 3 contends during the stall
      out_ready = 5'b01111;
      set_req(0, 4, 1'b0);
      tick();
      chk("bp_lock_occ", 32'(out_occupied), 32'b10000);
      set_req(3, 4, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_stall%0d_grant", c), 32'(in_grant), 32'h0);
         tick();
      end
      chk("bp_hold_occ",   32'(out_occupied), 32'b10000);
      chk("bp_hold_owner", 32'(out_owner),    32'd0);
      out_ready   = '1;
      req_tail[0] = 1'b1;
      #1;
      chk("bp_resume_grant", 32'(in_grant), 32'b00001);
      tick();
      clear_reqs();
      chk("bp_release_occ", 32'(out_occupied), 32'h0);

      // Parallel locks plus an out-of-range id
      set_req(0, 1, 1'b1);
      set_req(1, 0, 1'b1);
      set_req(2, 6, 1'b1);
      #1;
      chk("par_pre_bad", 32'(bad_req), 32'h0);
      tick();
      chk("par_occ",   32'(out_occupied), 32'b00011);
      chk("par_owner", 32'(out_owner),    32'd1);
      chk("par_grant", 32'(in_grant),     32'b00011);
      chk("par_bad",   32'(bad_req),      32'h1);
      tick();
      clear_reqs();
      chk("par_release_occ", 32'(out_occupied), 32'h0);
      tick();
      chk("bad_sticky", 32'(bad_req), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/port_allocator_rr.md
Name: port_allocator_rr

Overview:
- Parametrised, sequential successor to the router's per-port priority logic.
- Each output port holds an occupied/owner lock for a whole packet (head to tail).
- Free outputs are granted by round-robin among requesting input ports, with a per-output rotating priority pointer.
- Sits between the per-input routing lookup and the crossbar. It drives the crossbar select (out_owner) and the per-input flit-accept strobes (in_grant).

Parameters:
- PORTS, 5, number of input ports and number of output ports (equal).
- LOG_PORTS, 3, width of a port id; must satisfy 2^LOG_PORTS >= PORTS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  PORTS  bit i: input i holds a flit at its head.
- req_outport  input  PORTS*LOG_PORTS  field i (bits i*LOG_PORTS +: LOG_PORTS): output id requested by input i.
- req_tail  input  PORTS  bit i: the flit at input i is the tail (single-flit packet: head and tail both 1).
- out_ready  input  PORTS  bit o: downstream of output o can accept a flit this cycle.
- in_grant  output  PORTS  bit i: input i's flit is transferred this cycle (combinational).
- out_occupied  output  PORTS  bit o: output o is locked.
- out_owner  output  PORTS*LOG_PORTS  field o: input currently owning output o; 0 when free.
- bad_req  output  1  sticky flag: a valid request named an output id >= PORTS.

Behaviour:
- Reset (async, immediate):
  - out_occupied = 0, all out_owner fields = 0, all priority pointers = 0, bad_req = 0.
  - in_grant = 0 while rst is high.
  - Reset asserted mid-packet drops every lock; no flit is granted until rst deasserts.
- Per-output state machine:
  - FREE:
    - Candidate set C = { i : req_valid[i] and req_outport[i] == o }.
    - Input i is excluded from C if it already owns another output. This cannot happen in legal traffic, but it is masked anyway.
    - If C is non-empty, at the next edge: go to LOCKED, out_owner = winner, pointer = (winner+1) mod PORTS.
    - Winner = first member of C searching upward from the pointer with wrap-around (PORTS-1 wraps to 0).
    - If C is empty: stay FREE; pointer unchanged.
  - LOCKED:
    - Transfer condition T = req_valid[owner] and req_outport[owner] == o and out_ready[o].
    - in_grant[owner] = T, combinational, same cycle.
    - If T and req_tail[owner]: return to FREE at the next edge and reset out_owner to 0.
    - If T without tail: stay LOCKED.
    - If not T: stay LOCKED; no timeout or pre-emption.
- Latency:
  - A head arriving at a FREE output is locked at the edge after it is presented.
  - First in_grant occurs the cycle after that (1-cycle allocation latency) if out_ready is high.
- Release/re-allocate: on a tail transfer the output goes FREE at the next edge. Re-arbitration happens in that FREE cycle and the new lock lands one edge later, giving exactly one bubble cycle between packets on the same output.
- Allocation does not transfer a flit: a head is granted only while the output is LOCKED.
- Simultaneous requests: PORTS outputs arbitrate independently in the same cycle. Distinct outputs may lock to distinct inputs on the same edge.
- in_grant is one-hot or zero per input (an input requests one output at a time).
- Invalid id: a valid request with req_outport >= PORTS joins no candidate set and sets bad_req at the next edge; bad_req stays set until reset.
- out_ready is ignored while FREE (allocation does not depend on downstream space).

Test Plan:
- Reset/idle: assert rst mid-packet (output 2 locked to input 1) -> out_occupied=0, out_owner=0, in_grant=0 immediately; after release, the same request relocks after 1 edge.
- Single-flit packet: input 3 requests output 0 with tail=1, out_ready=1 at cycle 0 -> locked at edge 1, in_grant[3]=1 in cycle 1, out_occupied[0]=0 after edge 2.
- Round-robin fairness: inputs 0, 2, 4 continuously send 1-flit packets to output 1 with pointer=0 -> winners 0, 2, 4, 0 in order, each packet separated by one bubble cycle.
- Wormhole hold: input 1 sends a 4-flit packet to output 3 while input 2 also requests output 3 -> input 2 gets no grant until input 1's tail transfers; input 2 is locked on the following edge.
- Back-pressure: locked output 4 with out_ready=0 for 5 cycles -> in_grant stays 0 and the lock is held; out_ready=1 resumes transfers with no re-arbitration.
- Parallel and invalid: inputs 0→1 and 1→0 requested in the same cycle -> both lock on the same edge; input 2 requests id 6 -> bad_req=1 at the next edge, sticky.
